// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse-train scheduler: state encoding, job config layout,
// parameter defaults and small helpers used by the top and the arbiter.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StGap    = 2'd3
    } pt_state_e;

    // Job config word is {sets[2:0], pulses[2:0]}.
    localparam int unsigned CfgW      = 6;
    localparam int unsigned PulsesW   = 3;
    localparam int unsigned PulsesLsb = 0;
    localparam int unsigned SetsW     = 3;
    localparam int unsigned SetsLsb   = 3;

    localparam int unsigned GapTicksDefault     = 2;
    localparam int unsigned TimeoutTicksDefault = 200;

    // Requester identities as carried by OWNER and the served-last record.
    localparam logic ReqA = 1'b0;
    localparam logic ReqB = 1'b1;

    // Counter width able to hold max_val itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [PulsesW-1:0] cfg_pulses(input logic [CfgW-1:0] cfg);
        return cfg[PulsesLsb +: PulsesW];
    endfunction

    function automatic logic [SetsW-1:0] cfg_sets(input logic [CfgW-1:0] cfg);
        return cfg[SetsLsb +: SetsW];
    endfunction

endpackage

// File: rtl/pt_rr_arbiter.sv
// Two-requester round-robin: a lone request wins outright, a tie goes to the requester
// that was not served last. Bit 0 is requester A, bit 1 is requester B.
module pt_rr_arbiter
    import pulse_train_pkg::*;
(
    input  logic [1:0] i_reqs,
    input  logic       i_served_last,
    output logic [1:0] o_winner
);

    always_comb begin
        o_winner = 2'b00;
        unique case (i_reqs)
            2'b01:   o_winner = 2'b01;
            2'b10:   o_winner = 2'b10;
            2'b11:   o_winner = (i_served_last == ReqB) ? 2'b01 : 2'b10;
            default: o_winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/pulse_train_scheduler.sv
// Grants one of two requesters, launches the pulse-train engine with the winner's config,
// supervises the run with a TICK-based timeout and enforces an idle gap between jobs.
module pulse_train_scheduler
    import pulse_train_pkg::*;
#(
    parameter int unsigned GAP_TICKS     = GapTicksDefault,
    parameter int unsigned TIMEOUT_TICKS = TimeoutTicksDefault
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               TICK,
    input  logic               REQ_A,
    input  logic               REQ_B,
    input  logic [CfgW-1:0]    CFG_A,
    input  logic [CfgW-1:0]    CFG_B,
    output logic               GNT_A,
    output logic               GNT_B,
    output logic               ENG_START,
    output logic [PulsesW-1:0] ENG_PULSES,
    output logic [SetsW-1:0]   ENG_SETS,
    input  logic               ENG_DONE,
    output logic               BUSY,
    output logic               OWNER,
    output logic               ERR_TIMEOUT
);

    localparam int unsigned MaxTicks = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int unsigned CntW     = cnt_width(MaxTicks);

    localparam logic [CntW-1:0] GapLimit     = CntW'(GAP_TICKS);
    localparam logic [CntW-1:0] TimeoutLimit = CntW'(TIMEOUT_TICKS);

    pt_state_e          r_state;
    logic [CntW-1:0]    r_cnt;
    logic               r_gnt_a;
    logic               r_gnt_b;
    logic               r_eng_start;
    logic [PulsesW-1:0] r_pulses;
    logic [SetsW-1:0]   r_sets;
    logic               r_owner;
    logic               r_last;
    logic               r_err;

    logic [1:0]         w_winner;
    logic [CfgW-1:0]    w_sel_cfg;
    logic [CntW-1:0]    w_cnt_next;
    logic               w_gap_hit;
    logic               w_timeout_hit;

    pt_rr_arbiter u_arbiter (
        .i_reqs        ({REQ_B, REQ_A}),
        .i_served_last (r_last),
        .o_winner      (w_winner)
    );

    assign w_sel_cfg  = w_winner[1] ? CFG_B : CFG_A;
    assign w_cnt_next = r_cnt + CntW'(TICK);

    // Compare with >= so a zero limit exits on the first cycle of the state.
    assign w_gap_hit     = (w_cnt_next >= GapLimit);
    assign w_timeout_hit = (w_cnt_next >= TimeoutLimit);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_eng_start <= 1'b0;
            r_pulses    <= '0;
            r_sets      <= '0;
            r_owner     <= ReqA;
            r_last      <= ReqB;
            r_err       <= 1'b0;
        end else begin
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_eng_start <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (|w_winner) begin
                        r_gnt_a  <= w_winner[0];
                        r_gnt_b  <= w_winner[1];
                        r_owner  <= w_winner[1] ? ReqB : ReqA;
                        r_pulses <= cfg_pulses(w_sel_cfg);
                        r_sets   <= cfg_sets(w_sel_cfg);
                        r_cnt    <= '0;
                        r_state  <= StLaunch;
                    end
                end

                StLaunch: begin
                    r_eng_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= StRun;
                end

                StRun: begin
                    // Completion outranks a timeout reached on the same cycle.
                    if (ENG_DONE) begin
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                        r_state <= StGap;
                    end else if (w_timeout_hit) begin
                        r_err   <= 1'b1;
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                        r_state <= StGap;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                StGap: begin
                    if (w_gap_hit) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign GNT_A       = r_gnt_a;
    assign GNT_B       = r_gnt_b;
    assign ENG_START   = r_eng_start;
    assign ENG_PULSES  = r_pulses;
    assign ENG_SETS    = r_sets;
    assign BUSY        = (r_state != StIdle);
    assign OWNER       = r_owner;
    assign ERR_TIMEOUT = r_err;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Randomized bench for pulse_train_scheduler: a transaction-level model predicts each grant,
// a monitor pops predictions when the DUT grants and checks the launch that follows.
module tb_pulse_train_scheduler;

    localparam int unsigned GapT = 2;
    localparam int unsigned ToT  = 3;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       TICK;
    logic       REQ_A;
    logic       REQ_B;
    logic [5:0] CFG_A;
    logic [5:0] CFG_B;
    logic       GNT_A;
    logic       GNT_B;
    logic       ENG_START;
    logic [2:0] ENG_PULSES;
    logic [2:0] ENG_SETS;
    logic       ENG_DONE;
    logic       BUSY;
    logic       OWNER;
    logic       ERR_TIMEOUT;

    always #5 CLOCK_50 = ~CLOCK_50;

    pulse_train_scheduler #(
        .GAP_TICKS     (GapT),
        .TIMEOUT_TICKS (ToT)
    ) u_dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .TICK        (TICK),
        .REQ_A       (REQ_A),
        .REQ_B       (REQ_B),
        .CFG_A       (CFG_A),
        .CFG_B       (CFG_B),
        .GNT_A       (GNT_A),
        .GNT_B       (GNT_B),
        .ENG_START   (ENG_START),
        .ENG_PULSES  (ENG_PULSES),
        .ENG_SETS    (ENG_SETS),
        .ENG_DONE    (ENG_DONE),
        .BUSY        (BUSY),
        .OWNER       (OWNER),
        .ERR_TIMEOUT (ERR_TIMEOUT)
    );

    typedef struct packed {
        logic       b;
        logic [5:0] cfg;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model: who was served last (0=A, 1=B), sticky error, pending requests.
    bit m_last;
    bit m_err;
    bit pend_a;
    bit pend_b;
    bit aborted;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt_a"}, int'(GNT_A), 0);
        chk({tag, "_gnt_b"}, int'(GNT_B), 0);
        chk({tag, "_eng_start"}, int'(ENG_START), 0);
        chk({tag, "_eng_pulses"}, int'(ENG_PULSES), 0);
        chk({tag, "_eng_sets"}, int'(ENG_SETS), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_owner"}, int'(OWNER), 0);
        chk({tag, "_err"}, int'(ERR_TIMEOUT), 0);
    endtask

    task automatic do_reset(input string tag);
        RESET_N = 1'b0;
        step();
        chk_outputs_zero(tag);
        RESET_N = 1'b1;
        m_last = 1'b1;
        m_err  = 1'b0;
    endtask

    task automatic pulse_tick();
        TICK = 1'b1;
        step();
        TICK = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    // mode: 0 = done after 0..2 ticks, 1 = timeout, 2 = done together with the timeout tick.
    // rst:  0 = none, 1 = reset during RUN, 2 = reset during GAP.
    task automatic run_job(input bit ra, input bit rb, input logic [5:0] ca,
                           input logic [5:0] cb, input int mode, input int rst);
        bit         win_b;
        logic [5:0] win_cfg;
        int         lat;
        int         n;
        if (aborted) return;
        if (ra) begin
            REQ_A  = 1'b1;
            CFG_A  = ca;
            pend_a = 1'b1;
        end
        if (rb) begin
            REQ_B  = 1'b1;
            CFG_B  = cb;
            pend_b = 1'b1;
        end
        if (pend_a && pend_b) win_b = (m_last == 1'b0);
        else                  win_b = pend_b;
        win_cfg = win_b ? CFG_B : CFG_A;
        exp_q.push_back('{b: win_b, cfg: win_cfg});

        step();
        lat = 1;
        while (!(GNT_A || GNT_B) && lat < 10) begin
            step();
            lat++;
        end
        chk("grant_latency", lat, 1);
        if (!(GNT_A || GNT_B)) begin
            aborted = 1'b1;
            return;
        end

        // Granted: withdraw the winner and scramble its config; the latched job must not care.
        if (win_b) begin
            REQ_B  = 1'b0;
            pend_b = 1'b0;
            CFG_B  = 6'($urandom);
        end else begin
            REQ_A  = 1'b0;
            pend_a = 1'b0;
            CFG_A  = 6'($urandom);
        end
        ENG_DONE = 1'($urandom_range(0, 1));
        TICK     = 1'($urandom_range(0, 1));
        step();
        ENG_DONE = 1'b0;
        TICK     = 1'b0;
        chk("busy_run", int'(BUSY), 1);

        if (rst == 1) begin
            if ($urandom_range(0, 1) == 1) pulse_tick();
            do_reset("rst_run");
            return;
        end

        if (mode == 0) begin
            n = $urandom_range(0, 2);
            repeat (n) pulse_tick();
        end else begin
            repeat (ToT - 1) pulse_tick();
        end
        chk("err_in_run", int'(ERR_TIMEOUT), int'(m_err));
        chk("hold_pulses", int'(ENG_PULSES), int'(win_cfg[2:0]));
        chk("hold_sets", int'(ENG_SETS), int'(win_cfg[5:3]));

        if (mode == 1) begin
            TICK = 1'b1;
        end else if (mode == 2) begin
            TICK     = 1'b1;
            ENG_DONE = 1'b1;
        end else begin
            ENG_DONE = 1'b1;
        end
        step();
        TICK     = 1'b0;
        ENG_DONE = 1'b0;
        if (mode == 1) m_err = 1'b1;
        m_last = win_b;
        chk("err_after_run", int'(ERR_TIMEOUT), int'(m_err));
        chk("busy_gap", int'(BUSY), 1);

        ENG_DONE = 1'($urandom_range(0, 1));
        TICK     = 1'b1;
        step();
        TICK     = 1'b0;
        ENG_DONE = 1'b0;
        chk("busy_gap_tick1", int'(BUSY), 1);

        if (rst == 2) begin
            do_reset("rst_gap");
            return;
        end

        repeat ($urandom_range(0, 2)) begin
            ENG_DONE = 1'($urandom_range(0, 1));
            step();
            ENG_DONE = 1'b0;
        end
        chk("busy_gap_idle_ticks", int'(BUSY), 1);
        TICK = 1'b1;
        step();
        TICK = 1'b0;
        chk("busy_after_gap", int'(BUSY), 0);
    endtask

    // Monitor: pops a prediction on every grant and checks the launch on the following cycle.
    initial begin
        bit         start_due;
        logic [5:0] due_cfg;
        exp_t       e;
        start_due = 1'b0;
        due_cfg   = '0;
        forever begin
            @(negedge CLOCK_50);
            if (start_due) begin
                chk("eng_start", int'(ENG_START), 1);
                chk("eng_pulses", int'(ENG_PULSES), int'(due_cfg[2:0]));
                chk("eng_sets", int'(ENG_SETS), int'(due_cfg[5:3]));
                start_due = 1'b0;
            end else begin
                chk("no_stray_start", int'(ENG_START), 0);
            end
            if (GNT_A || GNT_B) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'({GNT_B, GNT_A}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_who", int'({GNT_B, GNT_A}), e.b ? 2 : 1);
                    chk("owner", int'(OWNER), int'(e.b));
                    start_due = 1'b1;
                    due_cfg   = e.cfg;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int rst;
        bit ra;
        bit rb;
        RESET_N  = 1'b0;
        TICK     = 1'b0;
        REQ_A    = 1'b0;
        REQ_B    = 1'b0;
        CFG_A    = '0;
        CFG_B    = '0;
        ENG_DONE = 1'b0;
        m_last   = 1'b1;
        m_err    = 1'b0;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
        aborted  = 1'b0;

        repeat (3) step();
        chk_outputs_zero("por");
        RESET_N = 1'b1;
        step();
        chk("idle_no_req", int'(BUSY), 0);

        // Lone A with a fixed config, then a tie resolved by done-beats-timeout.
        run_job(1'b1, 1'b0, 6'b010_011, 6'h00, 0, 0);
        run_job(1'b1, 1'b1, 6'($urandom), 6'($urandom), 2, 0);
        // Leftover A runs into the timeout; the error must survive the next job.
        run_job(1'b0, 1'b0, 6'h00, 6'h00, 1, 0);
        run_job(1'b0, 1'b1, 6'h00, 6'($urandom), 0, 0);
        // Reset mid-run, then three held ties must alternate starting from A.
        run_job(1'b1, 1'b0, 6'($urandom), 6'h00, 0, 1);
        run_job(1'b1, 1'b1, 6'($urandom), 6'($urandom), 0, 0);
        run_job(1'b1, 1'b1, 6'($urandom), 6'($urandom), 0, 0);
        run_job(1'b1, 1'b1, 6'($urandom), 6'($urandom), 0, 0);
        run_job(1'b1, 1'b1, 6'($urandom), 6'($urandom), 0, 2);

        for (int j = 0; j < 30 && !aborted; j++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!pend_a && !pend_b && !ra && !rb) ra = 1'b1;
            mode = $urandom_range(0, 2);
            rst  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            run_job(ra, rb, 6'($urandom), 6'($urandom), mode, rst);
        end

        REQ_A  = 1'b0;
        REQ_B  = 1'b0;
        pend_a = 1'b0;
        pend_b = 1'b0;
        repeat (4) step();
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_at_end", int'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_scheduler.md
PULSE_TRAIN_SCHEDULER -- requirements
Module: pulse_train_scheduler

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 2, idle ticks enforced between consecutive jobs.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 200, ticks allowed in RUN before a job is aborted.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port TICK  input  1  one-cycle timebase strobe (1-second-class rollover).
REQ-006 SHALL have ports REQ_A, REQ_B  input  1 each  job request, held high until granted.
REQ-007 SHALL have ports CFG_A, CFG_B  input  6 each  job config {sets[2:0], pulses[2:0]}.
REQ-008 SHALL have ports GNT_A, GNT_B  output  1 each  one-cycle accept strobe.
REQ-009 SHALL have port ENG_START  output  1  one-cycle start strobe to the pulse-train engine.
REQ-010 SHALL have ports ENG_PULSES, ENG_SETS  output  3 each  latched job config, held stable from ENG_START until the job ends.
REQ-011 SHALL have port ENG_DONE  input  1  one-cycle engine completion strobe.
REQ-012 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port OWNER  output  1  requester of the current or last job (0=A, 1=B).
REQ-014 SHALL have port ERR_TIMEOUT  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, RUN, GAP.
REQ-016 IDLE: if any REQ is high, SHALL select a winner, latch its CFG into ENG_PULSES/ENG_SETS, pulse its GNT for that cycle, set OWNER, and go to LAUNCH.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins; a lone request always wins.
REQ-018 LAUNCH SHALL assert ENG_START for exactly one cycle and go to RUN (ENG_START = 1 cycle after GNT).
REQ-019 RUN SHALL go to GAP on ENG_DONE; ENG_DONE in IDLE, LAUNCH or GAP SHALL be ignored.
REQ-020 RUN SHALL count TICKs from zero; when the count reaches TIMEOUT_TICKS it SHALL set ERR_TIMEOUT and go to GAP.
REQ-021 If ENG_DONE and the timeout-reaching TICK coincide, done SHALL win: no error is set.
REQ-022 GAP SHALL count TICKs and go to IDLE when the count reaches GAP_TICKS; with GAP_TICKS=0, GAP SHALL last exactly one cycle.
REQ-023 The served-last record SHALL update on leaving RUN, whether by done or by timeout.
REQ-024 Changes on REQ/CFG outside the IDLE grant cycle SHALL NOT affect the running job.
REQ-025 Tick counters SHALL be wide enough for the maximum parameter value without wrap; they SHALL clear on every state entry.
REQ-026 ERR_TIMEOUT SHALL clear only on reset.

Reset
REQ-027 With RESET_N low at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 (GNT_*, ENG_START, ENG_PULSES, ENG_SETS, BUSY, OWNER, ERR_TIMEOUT), with served-last = B so that A wins the first tie.
REQ-028 Reset asserted mid-RUN or mid-GAP SHALL abandon the job with no GNT or ENG_START pulse in that cycle.

Structure
REQ-029 Package pulse_train_pkg SHALL hold the state encoding, the CFG field widths and offsets, and the GAP_TICKS/TIMEOUT_TICKS defaults.
REQ-030 The two-requester round-robin SHALL be a sub-module pt_rr_arbiter (inputs: reqs, served-last; output: one-hot winner).

Verification
REQ-031 Bench SHALL cover: REQ_A=1, CFG_A=6'b010_011 from reset -> GNT_A next edge, ENG_START one cycle later, ENG_PULSES=3, ENG_SETS=2, BUSY=1.
REQ-032 Bench SHALL cover: REQ_A and REQ_B held together for three jobs -> grants in the order A, B, A.
REQ-033 Bench SHALL cover: ENG_DONE in RUN with GAP_TICKS=2 -> BUSY drops 2 TICKs after entering GAP; a pending REQ_B is granted in the first IDLE cycle.
REQ-034 Bench SHALL cover: no ENG_DONE with TIMEOUT_TICKS=3 -> ERR_TIMEOUT=1 on the 3rd TICK in RUN, then GAP; ERR_TIMEOUT stays 1 through the next job.
REQ-035 Bench SHALL cover: ENG_DONE on the same cycle as the 3rd TICK -> ERR_TIMEOUT stays 0.
REQ-036 Bench SHALL cover: RESET_N=0 for one cycle during RUN -> all outputs 0 next edge; next tie is granted to A.
